// File: rtl/pipelined_adder_nbits.sv
// Pipelined adder/subtractor: WIDTH/SLICE carry stages, one register per slice.
// Each stage adds one slice with the carry registered by the previous stage.
// Not-yet-added operand slices ride along in skew registers. Finished low sum
// slices ride along in the growing s_q of each stage, so that one result
// leaves as a single word. A single advance enable freezes the whole pipe
// while the output is held.
module pipelined_adder_nbits #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SLICE;

    logic adv;

    // The pipe moves only when the output slot is empty or being drained.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // SLICE-bit add returning {carry_out, sum}.
    function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y,
                                                  input logic             c);
        return {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, c};
    endfunction

    // Signed overflow of the MSB slice. The carry into the MSB is recovered
    // from the MSB sum bit and the two MSB operand bits.
    function automatic logic slice_ovf(input logic x_msb,
                                       input logic y_msb,
                                       input logic s_msb,
                                       input logic c_out);
        return c_out ^ (x_msb ^ y_msb ^ s_msb);
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added when entering stage k.
        localparam int WI = WIDTH - k * SLICE;

        logic [WI-1:0]          op_a;
        logic [WI-1:0]          op_b;
        logic                   c_in;
        logic                   v_in;
        logic [SLICE:0]         res;
        logic [(k+1)*SLICE-1:0] s_d;
        logic [(k+1)*SLICE-1:0] s_q;
        logic                   c_q;
        logic                   v_q;

        if (k == 0) begin : g_in
            // Subtract is A + ~B + 1. cin only matters in add mode.
            assign op_a = a;
            assign op_b = sub ? ~b : b;
            assign c_in = sub | cin;
            assign v_in = in_valid;
            assign s_d  = res[SLICE-1:0];
        end else begin : g_chain
            assign op_a = g_stage[k-1].g_skew.a_q;
            assign op_b = g_stage[k-1].g_skew.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
            assign s_d  = {res[SLICE-1:0], g_stage[k-1].s_q};
        end

        assign res = slice_add(op_a[SLICE-1:0], op_b[SLICE-1:0], c_in);

        // Stage register: partial sum, slice carry and valid, frozen on stall.
        always_ff @(posedge clk) begin
            if (reset) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_d;
                c_q <= res[SLICE];
                v_q <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WI-SLICE-1:0] a_q;
            logic [WI-SLICE-1:0] b_q;

            // Skew registers: upper operand slices waiting for their stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= op_a[WI-1:SLICE];
                    b_q <= op_b[WI-1:SLICE];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Overflow flag, registered alongside the final slice.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= slice_ovf(op_a[SLICE-1], op_b[SLICE-1],
                                       res[SLICE-1], res[SLICE]);
                end
            end

            assign sum       = s_q;
            assign cout      = c_q;
            assign out_valid = v_q;
            assign ovf       = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipelined_adder_nbits.sv
// Bench for pipelined_adder_nbits. Three instances are used:
// 8/4 (index 0), 16/4 (index 1) and 4/4 (index 2).
// A queue per instance holds expected results and input-cycle tags.
module tb_pipelined_adder_nbits;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  iv, ci, su, ordy;
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic [2:0]  ir, ov, co, of;
    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic [3:0]  sum4;

    int W   [3] = '{8, 16, 4};
    int STG [3] = '{2, 4, 1};

    logic [17:0] expq [3][$];
    int          tq   [3][$];
    int          cycn   [3];
    int          stalls [3];
    int          pushes [3];
    int          nchk, npass;
    logic        obs_ov;
    logic [15:0] obs_sum;

    always #5 clk = ~clk;

    pipelined_adder_nbits #(.WIDTH(8), .SLICE(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .cin(ci[0]), .sub(su[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum8), .cout(co[0]), .ovf(of[0]));

    pipelined_adder_nbits #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .cin(ci[1]), .sub(su[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum16), .cout(co[1]), .ovf(of[1]));

    pipelined_adder_nbits #(.WIDTH(4), .SLICE(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2][3:0]), .b(bv[2][3:0]), .cin(ci[2]), .sub(su[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum4), .cout(co[2]), .ovf(of[2]));

    // Reference: {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic s);
        logic [16:0] m, ea, eb, full;
        logic [15:0] sm;
        logic        cy, ovfl;
        m    = (17'd1 << w) - 17'd1;
        ea   = {1'b0, a} & m;
        eb   = s ? (~{1'b0, b}) & m : {1'b0, b} & m;
        full = ea + eb + (s ? 17'd1 : {16'd0, c});
        sm   = full[15:0] & m[15:0];
        cy   = full[w];
        ovfl = (ea[w-1] == eb[w-1]) && (sm[w-1] != ea[w-1]);
        return {ovfl, cy, sm};
    endfunction

    function automatic logic [15:0] cur_sum(input int d);
        if (d == 0) return {8'h00, sum8};
        if (d == 1) return sum16;
        return {12'h000, sum4};
    endfunction

    // One clock cycle on instance d; called at a falling edge, returns at the next one.
    task automatic cyc(input int d, input logic vi, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input logic r);
        logic [17:0] e;
        logic [15:0] sv;
        int          tin;
        iv[d] = vi; av[d] = a; bv[d] = b; ci[d] = c; su[d] = s; ordy[d] = r;
        #1;
        sv      = cur_sum(d);
        obs_ov  = ov[d];
        obs_sum = sv;
        nchk++;
        if (ir[d] !== (~ov[d] | r))
            $display("FAIL in_ready[%0d]: got %b want %b", d, ir[d], ~ov[d] | r);
        else npass++;
        if (ov[d] === 1'b1 && r) begin
            nchk++;
            if (expq[d].size() == 0) begin
                $display("FAIL spurious_result[%0d]: got sum %h with no result pending", d, sv);
            end else begin
                npass++;
                e   = expq[d].pop_front();
                tin = tq[d].pop_front();
                nchk++;
                if ({of[d], co[d], sv} !== e)
                    $display("FAIL result[%0d]: got ovf/cout/sum %b/%b/%h want %b/%b/%h",
                             d, of[d], co[d], sv, e[17], e[16], e[15:0]);
                else npass++;
                nchk++;
                if (cycn[d] - stalls[d] - tin != STG[d])
                    $display("FAIL latency[%0d]: got %0d want %0d", d, cycn[d] - stalls[d] - tin, STG[d]);
                else npass++;
            end
        end
        if (vi && ir[d] === 1'b1) begin
            expq[d].push_back(model(W[d], a, b, c, s));
            tq[d].push_back(cycn[d] - stalls[d]);
            pushes[d]++;
        end
        if (ov[d] === 1'b1 && !r) stalls[d]++;
        cycn[d]++;
        @(negedge clk);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while ((expq[d].size() != 0 || ov[d] === 1'b1) && n < 40) begin
            cyc(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        nchk++;
        if (expq[d].size() != 0)
            $display("FAIL drain[%0d]: got %0d results still pending want 0", d, expq[d].size());
        else npass++;
    endtask

    // Reset pulse at a falling edge, then check the idle output state of the 8-bit unit.
    task automatic pulse_reset(input string tag);
        reset = 1'b1; iv = '0; ordy = '0;
        for (int d = 0; d < 3; d++) begin expq[d].delete(); tq[d].delete(); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        nchk++;
        if (ov[0] !== 1'b0) $display("FAIL %s_out_valid: got %b want 0", tag, ov[0]); else npass++;
        nchk++;
        if (sum8 !== 8'h00) $display("FAIL %s_sum: got %h want 00", tag, sum8); else npass++;
        nchk++;
        if ({co[0], of[0]} !== 2'b00) $display("FAIL %s_cout_ovf: got %b want 00", tag, {co[0], of[0]}); else npass++;
        nchk++;
        if (ir[0] !== 1'b1) $display("FAIL %s_in_ready: got %b want 1", tag, ir[0]); else npass++;
    endtask

    task automatic test_reset();
        pulse_reset("reset");
    endtask

    task automatic test_add_carry();
        cyc(0, 1'b1, 16'h99, 16'h99, 1'b1, 1'b0, 1'b1);
        cyc(0, 1'b1, 16'h99, 16'h99, 1'b0, 1'b0, 1'b1);
        drain(0);
    endtask

    task automatic test_overflow_sub();
        cyc(0, 1'b1, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b1);
        cyc(0, 1'b1, 16'h05, 16'h07, 1'b1, 1'b1, 1'b1);
        cyc(0, 1'b1, 16'h80, 16'h01, 1'b0, 1'b1, 1'b1);
        drain(0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] sa [4] = '{16'h01, 16'h0F, 16'hF0, 16'hFF};
        logic [15:0] sb [4] = '{16'h01, 16'h01, 16'h10, 16'h01};
        for (int k = 0; k < 7; k++) begin
            if (k < 4) cyc(0, 1'b1, sa[k], sb[k], 1'b0, 1'b0, 1'b1);
            else       cyc(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            nchk++;
            if (obs_ov !== (k >= 2 && k <= 5))
                $display("FAIL stream_valid cycle %0d: got %b want %b", k, obs_ov, (k >= 2 && k <= 5));
            else npass++;
        end
        drain(0);
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        cyc(0, 1'b1, 16'h11, 16'h22, 1'b0, 1'b0, 1'b1);
        cyc(0, 1'b1, 16'h40, 16'h05, 1'b0, 1'b0, 1'b1);
        cyc(0, 1'b1, 16'hAA, 16'hAA, 1'b0, 1'b0, 1'b0);
        held = obs_sum;
        nchk++;
        if (obs_ov !== 1'b1 || held !== 16'h0033)
            $display("FAIL stall_first: got valid %b sum %h want 1 0033", obs_ov, held);
        else npass++;
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1'b1, 16'(k + 3), 16'h5A, 1'b1, 1'b0, 1'b0);
            nchk++;
            if (obs_ov !== 1'b1 || obs_sum !== held)
                $display("FAIL stall_hold %0d: got valid %b sum %h want 1 %h", k, obs_ov, obs_sum, held);
            else npass++;
        end
        drain(0);
    endtask

    task automatic test_reset_midstream();
        cyc(0, 1'b1, 16'h21, 16'h12, 1'b0, 1'b0, 1'b1);
        cyc(0, 1'b1, 16'h31, 16'h13, 1'b0, 1'b0, 1'b1);
        pulse_reset("midreset");
        cyc(0, 1'b1, 16'h03, 16'h04, 1'b0, 1'b0, 1'b1);
        drain(0);
    endtask

    task automatic test_sweep(input int d);
        int          n = 0;
        logic [31:0] msk;
        msk = (32'd1 << W[d]) - 32'd1;
        pushes[d] = 0;
        while (pushes[d] < 10000 && n < 40000) begin
            cyc(d, $urandom_range(0, 3) != 0, 16'($urandom & msk), 16'($urandom & msk),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            n++;
        end
        nchk++;
        if (pushes[d] < 10000)
            $display("FAIL sweep_inputs[%0d]: got %0d accepted want 10000", d, pushes[d]);
        else npass++;
        drain(d);
    endtask

    initial begin
        nchk = 0; npass = 0;
        reset = 1'b1; iv = '0; ci = '0; su = '0; ordy = '0;
        for (int d = 0; d < 3; d++) begin
            av[d] = '0; bv[d] = '0; cycn[d] = 0; stalls[d] = 0; pushes[d] = 0;
        end
        @(negedge clk);
        test_reset();
        test_add_carry();
        test_overflow_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_sweep(1);
        test_sweep(2);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
